s38584_g7xx_chain_seq: RTL and testbench



---
 rtl/s38584_g7xx_chain_seq_if.sv | 29 ++
 rtl/s38584_g7xx_chain_seq.sv | 150 +++++++++++++++
 tb/tb_s38584_g7xx_chain_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s38584_g7xx_chain_seq_if.sv
// Bundle of the g7xx chain control strobes and status outputs.
// The master side is the environment and the slave side is the chain sequencer.
interface s38584_g7xx_chain_seq_if #(
  parameter int STAGES = 13
);
  // Strobes are level-sampled on every CK edge.
  // start is honoured only in IDLE, step only in RUN and done_ack only in DONE.
  // g554 low forces RUN or DONE back to IDLE.
  logic              g554;
  logic              arm_q;
  logic              start;
  logic              step;
  logic              done_ack;
  logic [STAGES-1:0] stage_q;
  logic              g807;
  logic              busy;
  logic              abort_p;
  logic [1:0]        state_dbg;  // 0 idle, 1 run, 2 done

  modport master (
    output g554, arm_q, start, step, done_ack,
    input  stage_q, g807, busy, abort_p, state_dbg
  );

  modport slave (
    input  g554, arm_q, start, step, done_ack,
    output stage_q, g807, busy, abort_p, state_dbg
  );
endinterface

// File: rtl/s38584_g7xx_chain_seq.sv
// Sequencer for the g7xx stage chain: a one-hot token walks g739..g802 and then raises g807.
// The optional stall watchdog is enabled by defining S38584_CHAIN_TIMEOUT_EN.
module s38584_g7xx_chain_seq #(
  parameter int STAGES  = 13,
  parameter int TIMEOUT = 64
) (
  input logic                      CK,
  input logic                      g35,
  s38584_g7xx_chain_seq_if.slave   bus
);
  localparam int POS_W = $clog2(STAGES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  if (STAGES < 2 || STAGES > 32) begin : g_bad_stages
    $error("s38584_g7xx_chain_seq: STAGES must be in 2..32");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("s38584_g7xx_chain_seq: TIMEOUT must be at least 2");
  end

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [STAGES-1:0] token_q, token_d;
  logic              g807_q, g807_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;
  logic              last_pos;
  logic              stall_abort;
  logic              abort_req;

  assign last_pos = (pos_q == POS_W'(STAGES - 1));

`ifdef S38584_CHAIN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_q, wd_d;

  // A step in the expiry cycle counts as progress, so it suppresses the abort.
  assign stall_abort = (state_q == ST_RUN) && !bus.step && (wd_q == WD_W'(TIMEOUT - 1));
`else
  assign stall_abort = 1'b0;
`endif

  assign abort_req = ((state_q != ST_IDLE) && !bus.g554) || stall_abort;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    token_d = token_q;
    g807_d  = g807_q;
    busy_d  = busy_q;
    abort_d = 1'b0;
`ifdef S38584_CHAIN_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    if (abort_req) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      token_d = '0;
      g807_d  = 1'b0;
      busy_d  = 1'b0;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pos_d   = '0;
          token_d = '0;
          g807_d  = 1'b0;
          busy_d  = 1'b0;
          if (bus.start && bus.arm_q && bus.g554) begin
            state_d = ST_RUN;
            token_d = {{(STAGES-1){1'b0}}, 1'b1};
            busy_d  = 1'b1;
`ifdef S38584_CHAIN_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
        end
        ST_RUN: begin
          if (bus.step) begin
`ifdef S38584_CHAIN_TIMEOUT_EN
            wd_d = '0;
`endif
            if (last_pos) begin
              state_d = ST_DONE;
              token_d = '0;
              g807_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              pos_d   = pos_q + POS_W'(1);
              token_d = token_q << 1;
            end
          end else begin
`ifdef S38584_CHAIN_TIMEOUT_EN
            wd_d = wd_q + WD_W'(1);
`endif
          end
        end
        ST_DONE: begin
          // A start arriving together with done_ack is dropped; only the return to IDLE happens.
          if (bus.done_ack) begin
            state_d = ST_IDLE;
            g807_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pos_d   = '0;
          token_d = '0;
          g807_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (!g35) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      token_q <= '0;
      g807_q  <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef S38584_CHAIN_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      token_q <= token_d;
      g807_q  <= g807_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
`ifdef S38584_CHAIN_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.stage_q   = token_q;
  assign bus.g807      = g807_q;
  assign bus.busy      = busy_q;
  assign bus.abort_p   = abort_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_s38584_g7xx_chain_seq.sv
// Bench for s38584_g7xx_chain_seq: directed vector table, watchdog sequences, then random traffic against a reference model.
module tb_s38584_g7xx_chain_seq;
  localparam int STAGES = 13;
`ifdef S38584_CHAIN_TIMEOUT_EN
  localparam int TIMEOUT = 4;
`else
  localparam int TIMEOUT = 64;
`endif
  localparam int W = STAGES + 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  // clock / reset
  logic CK = 1'b0;
  logic g35;
  always #5 CK = ~CK;

  s38584_g7xx_chain_seq_if #(.STAGES(STAGES)) bus ();

  s38584_g7xx_chain_seq #(.STAGES(STAGES), .TIMEOUT(TIMEOUT)) u_dut (
    .CK  (CK),
    .g35 (g35),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic              rst_n;
    logic              en;
    logic              arm;
    logic              st;
    logic              stp;
    logic              ack;
    logic [STAGES-1:0] exp_stage;
    logic              exp_g807;
    logic              exp_busy;
    logic              exp_abort;
  } vec_t;
  vec_t vecs[$];

  // reference model: mode, token position and stall count
  int m_mode, m_pos, m_wd;
  bit m_abort;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic g, input logic a, input logic s,
                       input logic st, input logic k);
    g35          = r;
    bus.g554     = g;
    bus.arm_q    = a;
    bus.start    = s;
    bus.step     = st;
    bus.done_ack = k;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  function automatic void add(input logic r, input logic g, input logic a, input logic s,
                              input logic st, input logic k, input logic [STAGES-1:0] stg,
                              input logic o, input logic b, input logic ab);
    vec_t v;
    v = '{r, g, a, s, st, k, stg, o, b, ab};
    vecs.push_back(v);
  endfunction

  // start, STAGES-1 shifts, then the terminal step into DONE
  function automatic void add_walk_to_done();
    logic [STAGES-1:0] one;
    one = 1;
    add(1, 1, 1, 1, 1, 0, one, 0, 1, 0);
    for (int i = 1; i < STAGES; i++) add(1, 1, 1, 0, 1, 0, one << i, 0, 1, 0);
    add(1, 1, 1, 0, 1, 0, '0, 1, 0, 0);
  endfunction

  function automatic void model_step();
    m_abort = 1'b0;
    if (!g35) begin
      m_mode = M_IDLE;
      m_pos  = 0;
      m_wd   = 0;
    end else if (m_mode == M_IDLE) begin
      if (bus.start && bus.arm_q && bus.g554) begin
        m_mode = M_RUN;
        m_pos  = 0;
        m_wd   = 0;
      end
    end else if (!bus.g554) begin
      m_mode  = M_IDLE;
      m_abort = 1'b1;
    end else if (m_mode == M_RUN) begin
      if (bus.step) begin
        m_wd = 0;
        if (m_pos == STAGES - 1) m_mode = M_DONE;
        else m_pos = m_pos + 1;
      end else begin
`ifdef S38584_CHAIN_TIMEOUT_EN
        if (m_wd == TIMEOUT - 1) begin
          m_mode  = M_IDLE;
          m_abort = 1'b1;
        end else begin
          m_wd = m_wd + 1;
        end
`endif
      end
    end else if (bus.done_ack) begin
      m_mode = M_IDLE;
    end
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [STAGES-1:0] s;
    s = '0;
    if (m_mode == M_RUN) s[m_pos] = 1'b1;
    return {s, (m_mode == M_DONE), (m_mode == M_RUN), m_abort};
  endfunction

  initial begin
    logic [STAGES-1:0] one;
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    bit saw_abort;
    one = 1;

    // reset, with start and step asserted
    add(0, 1, 1, 1, 1, 0, '0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, '0, 0, 0, 0);
    // full walk, hold in DONE, start ignored in DONE, acknowledge
    add_walk_to_done();
    add(1, 1, 1, 0, 0, 0, '0, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0, '0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 1, '0, 0, 0, 0);
    // arm qualifier, g554 low in IDLE, start ignored in RUN, arm dropped mid-walk
    add(1, 1, 0, 1, 0, 0, '0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, '0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, one, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, one, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add(1, 1, 0, 0, 1, 0, one << i, 0, 1, 0);
    // abort at 0x0020 with step high, then the pulse must be gone
    add(1, 0, 1, 0, 1, 0, '0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, '0, 0, 0, 0);
    // abort from DONE beats done_ack
    add_walk_to_done();
    add(1, 0, 1, 0, 0, 1, '0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, '0, 0, 0, 0);
    // start together with done_ack only returns to IDLE
    add_walk_to_done();
    add(1, 1, 1, 1, 0, 1, '0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, one, 0, 1, 0);

    drive(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].arm, vecs[i].st, vecs[i].stp, vecs[i].ack);
      tick();
      check($sformatf("vec%0d.stage_q", i), 32'(bus.stage_q), 32'(vecs[i].exp_stage));
      check($sformatf("vec%0d.g807", i), 32'(bus.g807), 32'(vecs[i].exp_g807));
      check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d.abort_p", i), 32'(bus.abort_p), 32'(vecs[i].exp_abort));
    end
    check("reset_state_dbg", 32'(bus.state_dbg), 32'(M_RUN));

    drive(0, 1, 1, 0, 0, 0);
    tick();
    check("reset_state_idle", 32'(bus.state_dbg), 32'(M_IDLE));
`ifdef S38584_CHAIN_TIMEOUT_EN
    // stall for TIMEOUT RUN cycles -> abort
    drive(1, 1, 1, 1, 0, 0);
    tick();
    check("wd_enter_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      tick();
      check($sformatf("wd_hold%0d_abort", i), 32'(bus.abort_p), 32'd0);
      check($sformatf("wd_hold%0d_busy", i), 32'(bus.busy), 32'd1);
    end
    tick();
    check("wd_expire_abort", 32'(bus.abort_p), 32'd1);
    check("wd_expire_busy", 32'(bus.busy), 32'd0);
    check("wd_expire_stage", 32'(bus.stage_q), 32'd0);
    tick();
    check("wd_pulse_end", 32'(bus.abort_p), 32'd0);
    // step in the expiry cycle wins
    drive(1, 1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    drive(1, 1, 1, 0, 1, 0);
    tick();
    check("wd_step_wins_abort", 32'(bus.abort_p), 32'd0);
    check("wd_step_wins_stage", 32'(bus.stage_q), 32'd2);
    check("wd_step_wins_busy", 32'(bus.busy), 32'd1);
`else
    // without the watchdog RUN holds indefinitely
    drive(1, 1, 1, 1, 0, 0);
    tick();
    saw_abort = 1'b0;
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.abort_p) saw_abort = 1'b1;
    end
    check("hold_no_abort", 32'(saw_abort), 32'd0);
    check("hold_busy", 32'(bus.busy), 32'd1);
    check("hold_stage", 32'(bus.stage_q), 32'd1);
`endif

    // random traffic against the model, starting from reset
    m_mode = M_IDLE;
    m_pos  = 0;
    m_wd   = 0;
    for (int c = 0; c < 600; c++) begin
      if (c == 0) drive(0, 1, 0, 0, 0, 0);
      else drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
      model_step();
      exp_q.push_back(model_outputs());
      tick();
      exp_v = exp_q.pop_front();
      act_v = {bus.stage_q, bus.g807, bus.busy, bus.abort_p};
      check($sformatf("rand%0d.outputs", c), 32'(act_v), 32'(exp_v));
      check($sformatf("rand%0d.state_dbg", c), 32'(bus.state_dbg), 32'(m_mode));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
